mvm_result_drain: RTL and testbench

- Downstream stage of the matrix-vector multiply core.
- After the core pulses done, this block captures the K result words the core streams out on data_out, one per cycle, and buffers them in a local FIFO.
- It re-emits the words on a valid/ready stream, tagging the last word of each frame, so a slower consumer can drain results without stalling the core.

---
 rtl/mvm_result_drain.sv | 203 ++++++++++++++++++++
 tb/tb_mvm_result_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_result_drain.sv
// Result drain for the matrix-vector multiply core.
// Optional build macro DRAIN_SAT_EN: saturate each captured word to a signed
// B-bit value at push time, which narrows the output stream to B bits.

// Generic single-clock FIFO with head-of-queue read port.
// Latency: a pushed word is visible at head_dat one cycle later.
// Backpressure: a push while full is accepted only alongside a pop; otherwise it is refused.
module mvm_drain_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Pointers wrap explicitly so any depth, including 1, stays modulo DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    // Storage array; contents are don't-care until pushed, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Captures K result words OUT_DELAY cycles after done and re-streams them with m_last on the final word.
// Latency: first word on m_data OUT_DELAY+1 cycles after done; one cycle through the FIFO.
// Backpressure: m_ready low holds the head stable; captures into a full FIFO are dropped and flag overflow.
module mvm_result_drain #(
    parameter int K         = 32,
    parameter int B         = 8,
    parameter int OUT_DELAY = 2,
    parameter int DEPTH     = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic done,
    input  logic [2*B-1:0] data_in,
`ifdef DRAIN_SAT_EN
    output logic [B-1:0]   m_data,
`else
    output logic [2*B-1:0] m_data,
`endif
    output logic m_valid,
    input  logic m_ready,
    output logic m_last,
    output logic busy,
    output logic overflow,
    output logic frame_miss,
    input  logic clr_err
);
`ifdef DRAIN_SAT_EN
    localparam int OW = B;
`else
    localparam int OW = 2 * B;
`endif
    localparam int FW = OW + 1;
    localparam int DW = $clog2(OUT_DELAY) + 1;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] dly_cnt, dly_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] head;
    logic [OW-1:0] cap_word;

`ifdef DRAIN_SAT_EN
    localparam logic signed [2*B-1:0] SAT_MAX = (2*B)'((2 ** (B - 1)) - 1);
    localparam logic signed [2*B-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp the wide signed result into the narrow signed output range.
    always_comb begin
        if ($signed(data_in) > SAT_MAX)      cap_word = SAT_MAX[B-1:0];
        else if ($signed(data_in) < SAT_MIN) cap_word = SAT_MIN[B-1:0];
        else                                 cap_word = data_in[B-1:0];
    end
`else
    assign cap_word = data_in;
`endif

    // Frame sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            dly_cnt <= '0;
            idx     <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
            idx     <= idx_nxt;
        end
    end

    // Next state: wait out the core's output delay, then capture exactly K words.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        idx_nxt   = idx;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (done) begin
                    if (OUT_DELAY == 1) begin
                        state_nxt = S_CAPTURE;
                    end else begin
                        state_nxt = S_WAIT;
                        dly_nxt   = DW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (dly_cnt == DW'(OUT_DELAY - 1)) state_nxt = S_CAPTURE;
                else                               dly_nxt   = dly_cnt + 1'b1;
            end
            S_CAPTURE: begin
                // idx advances even when the FIFO drops the word, keeping frame alignment.
                push = 1'b1;
                if (idx == IW'(K - 1)) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign pop     = m_valid && m_ready;
    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? head[FW-1:1] : '0;
    assign m_last  = m_valid && head[0];

    mvm_drain_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({cap_word, (idx == IW'(K - 1))}),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Sticky error flags; a fresh error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            frame_miss <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) overflow <= 1'b1;
            else if (clr_err)              overflow <= 1'b0;
            if (done && busy)              frame_miss <= 1'b1;
            else if (clr_err)              frame_miss <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mvm_result_drain.sv
// Bench for mvm_result_drain: two instances (DEPTH 32 and 16) share stimulus.
// Frames come from vector tables; multi-cycle corners are hand sequenced.
module tb_mvm_result_drain;
    localparam int K = 32;
    localparam int B = 8;
`ifdef DRAIN_SAT_EN
    localparam int OW = B;
`else
    localparam int OW = 2 * B;
`endif

    typedef struct {
        logic [2*B-1:0] din;
        logic [OW-1:0]  exp;
        logic           last;
    } vec_t;

    logic clk = 1'b0;
    logic reset, done, m_ready, m_ready16, clr_err;
    logic [2*B-1:0] data_in;
    logic [OW-1:0]  m_data, m_data16;
    logic m_valid, m_last, busy, overflow, frame_miss;
    logic m_valid16, m_last16, busy16, overflow16, frame_miss16;

    vec_t tav[K];
    vec_t tbv[K];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int stall_err = 0;
    logic          stall_pend = 1'b0;
    logic [OW-1:0] stall_dat = '0;

    logic [OW-1:0] rx_dat[$];
    logic          rx_last[$];
    int            rx_cyc[$];
    logic [OW-1:0] rx16_dat[$];
    logic          rx16_last[$];

    int   c0;
    logic busy_t1, busy_end, ovf16_at16, ovf16_at17;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mvm_result_drain #(.K(K), .B(B), .OUT_DELAY(2), .DEPTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .done(done), .data_in(data_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .overflow(overflow), .frame_miss(frame_miss), .clr_err(clr_err)
    );

    mvm_result_drain #(.K(K), .B(B), .OUT_DELAY(2), .DEPTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .done(done), .data_in(data_in),
        .m_data(m_data16), .m_valid(m_valid16), .m_ready(m_ready16), .m_last(m_last16),
        .busy(busy16), .overflow(overflow16), .frame_miss(frame_miss16), .clr_err(clr_err)
    );

    // Record every accepted word of the DEPTH=32 instance and watch head stability during stalls.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            rx_dat.push_back(m_data);
            rx_last.push_back(m_last);
            rx_cyc.push_back(cyc);
        end
        if (stall_pend && m_valid && (m_data != stall_dat)) stall_err = stall_err + 1;
        stall_pend = m_valid && !m_ready;
        stall_dat  = m_data;
    end

    // Record every accepted word of the DEPTH=16 instance.
    always @(negedge clk) begin
        if (m_valid16 && m_ready16) begin
            rx16_dat.push_back(m_data16);
            rx16_last.push_back(m_last16);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse done, then feed the table one word per cycle so word i is sampled OUT_DELAY+i cycles later.
    task automatic send_frame(input bit sel, input int miss_at, input int abort_at);
        done = 1'b1;
        step();
        c0      = cyc;
        busy_t1 = busy;
        done    = 1'b0;
        step();
        for (int i = 0; i < K; i++) begin
            if (i == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_m_valid", m_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_m_data", m_data, 0);
                return;
            end
            done    = (i == miss_at);
            clr_err = (i == miss_at);
            if (i == 16) ovf16_at16 = overflow16;
            if (i == 17) ovf16_at17 = overflow16;
            if (i == K - 1) busy_end = busy;
            data_in = sel ? tbv[i].din : tav[i].din;
            step();
        end
        done    = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic check_frame(input bit sel, input int base, input int start);
        for (int i = 0; i < K; i++) begin
            if (base + i < rx_dat.size()) begin
                chk($sformatf("data[%0d]", i), rx_dat[base + i], sel ? tbv[i].exp : tav[i].exp);
                chk($sformatf("last[%0d]", i), rx_last[base + i], sel ? tbv[i].last : tav[i].last);
                if (start >= 0) chk($sformatf("cycle[%0d]", i), rx_cyc[base + i], start + 2 + i);
            end else begin
                chk($sformatf("missing[%0d]", i), 0, 1);
            end
        end
    endtask

    initial begin
        int base, base16, stall0, n;
        for (int i = 0; i < K; i++) begin
            tav[i].din  = (2*B)'(i);
            tav[i].exp  = OW'(i);
            tav[i].last = (i == K - 1);
            tbv[i]      = tav[i];
        end
        tbv[0].din = (2*B)'(300);
        tbv[1].din = (2*B)'(-300);
        tbv[2].din = (2*B)'(127);
        tbv[3].din = (2*B)'(-128);
        tbv[4].din = (2*B)'(-5);
        tbv[5].din = (2*B)'(-129);
        tbv[6].din = (2*B)'(128);
`ifdef DRAIN_SAT_EN
        tbv[0].exp = OW'(127);
        tbv[1].exp = OW'(-128);
        tbv[2].exp = OW'(127);
        tbv[3].exp = OW'(-128);
        tbv[4].exp = OW'(-5);
        tbv[5].exp = OW'(-128);
        tbv[6].exp = OW'(127);
`else
        tbv[0].exp = OW'(300);
        tbv[1].exp = OW'(-300);
        tbv[2].exp = OW'(127);
        tbv[3].exp = OW'(-128);
        tbv[4].exp = OW'(-5);
        tbv[5].exp = OW'(-129);
        tbv[6].exp = OW'(128);
`endif

        reset = 1'b0; done = 1'b0; data_in = '0; clr_err = 1'b0;
        m_ready = 1'b1; m_ready16 = 1'b1;
        ovf16_at16 = 1'b0; ovf16_at17 = 1'b0; busy_t1 = 1'b0; busy_end = 1'b0;
        repeat (3) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_miss", frame_miss, 0);
        reset = 1'b1;
        step();

        // Basic frame with a consumer that is always ready.
        base = rx_dat.size();
        send_frame(0, -1, -1);
        chk("basic_busy_t1", busy_t1, 1);
        chk("basic_busy16_end", busy16, 0);
        chk("basic_busy_last_capture", busy_end, 1);
        step();
        chk("basic_busy_after", busy, 0);
        repeat (5) step();
        chk("basic_count", rx_dat.size(), base + K);
        check_frame(0, base, c0);

        // Back-pressure on both instances; the DEPTH=16 one must overflow after word 16.
        m_ready = 1'b0; m_ready16 = 1'b0;
        base = rx_dat.size(); base16 = rx16_dat.size(); stall0 = stall_err;
        send_frame(1, -1, -1);
        chk("ovf16_after_16", ovf16_at16, 0);
        chk("ovf16_after_17", ovf16_at17, 1);
        repeat (5) step();
        chk("bp_m_valid", m_valid, 1);
        chk("bp_overflow", overflow, 0);
        chk("bp_no_pop", rx_dat.size(), base);
        n = 0;
        while (rx_dat.size() < base + K && n < 400) begin
            m_ready = (n % 3 != 0);
            step();
            n++;
        end
        m_ready = 1'b1;
        repeat (3) step();
        chk("bp_count", rx_dat.size(), base + K);
        check_frame(1, base, -1);
        chk("bp_stall_stable", stall_err, stall0);
        chk("bp_drained", m_valid, 0);
        m_ready16 = 1'b1;
        repeat (25) step();
        chk("ovf16_count", rx16_dat.size(), base16 + 16);
        for (int i = 0; i < 16; i++) begin
            if (base16 + i < rx16_dat.size()) begin
                chk($sformatf("ovf16_data[%0d]", i), rx16_dat[base16 + i], tbv[i].exp);
                chk($sformatf("ovf16_last[%0d]", i), rx16_last[base16 + i], 0);
            end
        end
        chk("ovf16_empty", m_valid16, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf16_cleared", overflow16, 0);

        // done re-pulsed mid-capture with clr_err in the same cycle.
        base = rx_dat.size();
        send_frame(0, 8, -1);
        chk("miss_busy_last_capture", busy_end, 1);
        step();
        chk("miss_busy_after", busy, 0);
        chk("miss_flag", frame_miss, 1);
        chk("miss_flag16", frame_miss16, 1);
        repeat (40) step();
        chk("miss_count", rx_dat.size(), base + K);
        check_frame(0, base, c0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("miss_cleared", frame_miss, 0);

        // Reset at capture index 10, then a clean frame.
        send_frame(0, -1, 10);
        repeat (2) step();
        reset = 1'b1;
        repeat (5) step();
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_m_valid16", m_valid16, 0);
        chk("post_rst_busy", busy, 0);
        base = rx_dat.size();
        send_frame(0, -1, -1);
        repeat (5) step();
        chk("post_rst_count", rx_dat.size(), base + K);
        check_frame(0, base, c0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
